// File: rtl/mirrored_sys_ram_pkg.sv
// ---------------------------------------------------------------------------
// sys_ram_pkg
// Shared types and constants for the mirrored system RAM.
//
// Contents:
//   sys_ram_state_e  - clear sequencer states (CLEAR, READY)
//   SYS_RAM_LAT      - read latency in cycles from accept to rvalid
//   in_window()      - true when an address falls inside an aligned window
//
// Configuration macro: SYS_RAM_OUT_REG_EN
//   defined   -> extra output register on rdata/rvalid, SYS_RAM_LAT = 2
//   undefined -> rdata comes straight from the array read register, SYS_RAM_LAT = 1
// ---------------------------------------------------------------------------
package sys_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } sys_ram_state_e;

`ifdef SYS_RAM_OUT_REG_EN
   localparam int SYS_RAM_LAT = 2;
`else
   localparam int SYS_RAM_LAT = 1;
`endif

   // The window is aligned to its own size, so membership is simply a match
   // of every address bit above the window size.
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned log2);
      return (addr >> log2) == (base >> log2);
   endfunction

endpackage

// File: rtl/mirrored_sys_ram_if.sv
// ---------------------------------------------------------------------------
// mirrored_sys_ram_if
// CPU-side bus bundle for the mirrored system RAM.
//
// Signals:
//   bus_addr   CPU address (BUS_ADDR_W)
//   bus_wdata  write data (DATA_W)
//   bus_req    access request
//   bus_we     1 = write, 0 = read, qualified by bus_req
//   hit        address decodes inside the RAM window (combinational)
//   bus_ready  RAM can accept an access this cycle
//   rdata      read data, held until the next read completes
//   rvalid     one-cycle strobe marking rdata valid
//
// Modports:
//   master - the CPU/bus side driving requests
//   slave  - the RAM answering them
// ---------------------------------------------------------------------------
interface mirrored_sys_ram_if #(
   parameter int DATA_W     = 8,
   parameter int BUS_ADDR_W = 16
);

   logic [BUS_ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0]     bus_wdata;
   logic                  bus_req;
   logic                  bus_we;
   logic                  hit;
   logic                  bus_ready;
   logic [DATA_W-1:0]     rdata;
   logic                  rvalid;

   modport master (
      output bus_addr,
      output bus_wdata,
      output bus_req,
      output bus_we,
      input  hit,
      input  bus_ready,
      input  rdata,
      input  rvalid
   );

   modport slave (
      input  bus_addr,
      input  bus_wdata,
      input  bus_req,
      input  bus_we,
      output hit,
      output bus_ready,
      output rdata,
      output rvalid
   );

endinterface

// File: rtl/mirrored_sys_ram_array.sv
// ---------------------------------------------------------------------------
// sys_ram_array
// Single-port DATA_W x 2**ADDR_W memory with a registered read port.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-low; clears only the read register
//   wren      write data_in to addr at the clock edge
//   rden      capture mem[addr] into data_out at the clock edge
//   addr      word index (ADDR_W)
//   data_in   write data (DATA_W)
//   data_out  registered read data, held while rden is low
//
// The storage itself has no reset so that it maps onto block RAM; the
// initial contents are established by the clear sequencer in the top level.
// ---------------------------------------------------------------------------
module sys_ram_array #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wren,
   input  logic              rden,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Storage write port. Reads and writes never share a cycle, so no
   // read-during-write behaviour has to be defined.
   always_ff @(posedge clk) begin
      if (wren) begin
         mem[addr] <= data_in;
      end
   end

   // Read register: only updated by an accepted read, which is what lets the
   // top level present it as "held until the next read completes".
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out <= '0;
      end else if (rden) begin
         data_out <= mem[addr];
      end
   end

endmodule

// File: rtl/mirrored_sys_ram.sv
// ---------------------------------------------------------------------------
// mirrored_sys_ram
// CPU work RAM on the 6502 bus: window decode with address mirroring, a
// power-up / soft clear sequencer and a ready/valid handshake with a
// read-valid strobe.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   bus         mirrored_sys_ram_if.slave (addr/wdata/req/we in,
//               hit/bus_ready/rdata/rvalid out)
//   soft_clear  one-cycle pulse restarting the clear sequence
//   init_done   high once a clear sequence has completed
//
// Configuration macro: SYS_RAM_OUT_REG_EN
//   defined   -> extra output register on rdata/rvalid, read latency 2
//   undefined -> rdata straight from the array read register, latency 1
// ---------------------------------------------------------------------------
module mirrored_sys_ram
   import sys_ram_pkg::*;
#(
   parameter int                    DATA_W     = 8,
   parameter int                    ADDR_W     = 11,
   parameter int                    BUS_ADDR_W = 16,
   parameter logic [BUS_ADDR_W-1:0] WIN_BASE   = 16'h0000,
   parameter int                    WIN_LOG2   = 13,
   parameter logic [DATA_W-1:0]     CLEAR_VAL  = 8'h00
) (
   input  logic                clk,
   input  logic                reset,
   mirrored_sys_ram_if.slave   bus,
   input  logic                soft_clear,
   output logic                init_done
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   sys_ram_state_e    state;
   sys_ram_state_e    state_next;
   logic [CNT_W-1:0]  clr_idx;
   logic [CNT_W-1:0]  clr_idx_next;
   logic              init_done_next;

   logic              ready;
   logic              accept;
   logic              ram_wren;
   logic              ram_rden;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Window decode. Only the low ADDR_W bits index the array, so the bits
   // between ADDR_W and WIN_LOG2 are don't-cares and produce the mirrors.
   assign bus.hit       = in_window(32'(bus.bus_addr), 32'(WIN_BASE), WIN_LOG2);
   assign bus.bus_ready = ready;

   // Sequencer state, clear counter and init flag. Reset always restarts
   // the clear from index 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_next;
         clr_idx   <= clr_idx_next;
         init_done <= init_done_next;
      end
   end

   // Next-state and array control. During CLEAR the array port belongs to
   // the sequencer and the bus is held off; in READY a soft_clear pulse
   // drops bus_ready in the same cycle so it wins over any request.
   always_comb begin
      state_next     = state;
      clr_idx_next   = clr_idx;
      init_done_next = init_done;
      ready          = 1'b0;
      accept         = 1'b0;
      ram_wren       = 1'b0;
      ram_rden       = 1'b0;
      ram_addr       = bus.bus_addr[ADDR_W-1:0];
      ram_wdata      = bus.bus_wdata;

      case (state)
         CLEAR: begin
            ram_wren     = 1'b1;
            ram_addr     = clr_idx[ADDR_W-1:0];
            ram_wdata    = CLEAR_VAL;
            clr_idx_next = clr_idx + 1'b1;
            if (clr_idx == CNT_W'(DEPTH - 1)) begin
               state_next     = READY;
               init_done_next = 1'b1;
            end
         end
         READY: begin
            ready    = ~soft_clear;
            accept   = bus.bus_req & bus.hit & ready;
            ram_wren = accept & bus.bus_we;
            ram_rden = accept & ~bus.bus_we;
            if (soft_clear) begin
               state_next     = CLEAR;
               clr_idx_next   = '0;
               init_done_next = 1'b0;
            end
         end
      endcase
   end

   sys_ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk      (clk),
      .reset    (reset),
      .wren     (ram_wren),
      .rden     (ram_rden),
      .addr     (ram_addr),
      .data_in  (ram_wdata),
      .data_out (ram_rdata)
   );

   // Read-valid pipeline: bit 0 marks the array read register as freshly
   // loaded, the top bit is the externally visible strobe.
   logic [SYS_RAM_LAT-1:0] rvalid_pipe;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid_pipe <= '0;
      end else begin
         rvalid_pipe <= (rvalid_pipe << 1) | SYS_RAM_LAT'(ram_rden);
      end
   end

   assign bus.rvalid = rvalid_pipe[SYS_RAM_LAT-1];

`ifdef SYS_RAM_OUT_REG_EN
   // Output register stage: copy read data only when a read has just landed
   // in the array register, so rdata still holds between reads.
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (rvalid_pipe[0]) begin
         rdata_q <= ram_rdata;
      end
   end

   assign bus.rdata = rdata_q;
`else
   assign bus.rdata = ram_rdata;
`endif

endmodule

// File: tb/tb_mirrored_sys_ram.sv
// ---------------------------------------------------------------------------
// tb_mirrored_sys_ram
// Self-checking bench for mirrored_sys_ram: directed scenarios plus a
// randomized phase, all compared against a behavioural model that tracks
// memory contents, clear progress and the expected read results by cycle.
// ---------------------------------------------------------------------------
module tb_mirrored_sys_ram;

`ifdef SYS_RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int DEPTH = 2048;

   logic clk;
   logic reset;
   logic soft_clear;
   logic init_done;

   mirrored_sys_ram_if #(.DATA_W(8), .BUS_ADDR_W(16)) bus_if ();

   mirrored_sys_ram dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus_if),
      .soft_clear (soft_clear),
      .init_done  (init_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state
   typedef struct {
      int         due;
      logic [7:0] data;
   } pending_t;

   logic [7:0] mem_m [DEPTH];
   int         clear_left;
   logic       init_done_m;
   logic [7:0] rdata_m;
   pending_t   pend_q[$];
   int         cycle;

   int check_count;
   int error_count;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // One bus cycle. Entered and left at a falling edge.
   task automatic applyStimulus(input logic req, input logic we, input logic [15:0] addr,
                                input logic [7:0] wdata, input logic sc);
      logic     exp_hit;
      logic     exp_ready;
      int       idx;
      pending_t p;
      logic     exp_rvalid;

      bus_if.bus_req   = req;
      bus_if.bus_we    = we;
      bus_if.bus_addr  = addr;
      bus_if.bus_wdata = wdata;
      soft_clear       = sc;
      #1;
      exp_hit   = (addr < 16'h2000);
      exp_ready = (clear_left == 0) && !sc;
      checkOutput("hit", 32'(bus_if.hit), 32'(exp_hit));
      checkOutput("bus_ready", 32'(bus_if.bus_ready), 32'(exp_ready));

      @(posedge clk);
      idx = int'(addr) % DEPTH;
      if (clear_left > 0) begin
         mem_m[DEPTH - clear_left] = 8'h00;
         clear_left--;
         if (clear_left == 0) init_done_m = 1'b1;
      end else begin
         if (req && exp_hit && !sc) begin
            if (we) begin
               mem_m[idx] = wdata;
            end else begin
               p.due  = cycle + LAT;
               p.data = mem_m[idx];
               pend_q.push_back(p);
            end
         end
         if (sc) begin
            clear_left  = DEPTH;
            init_done_m = 1'b0;
         end
      end
      #1;
      cycle++;
      exp_rvalid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cycle) begin
         exp_rvalid = 1'b1;
         rdata_m    = pend_q[0].data;
         void'(pend_q.pop_front());
      end
      checkOutput("rvalid", 32'(bus_if.rvalid), 32'(exp_rvalid));
      checkOutput("rdata", 32'(bus_if.rdata), 32'(rdata_m));
      checkOutput("init_done", 32'(init_done), 32'(init_done_m));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
   endtask

   // Clear period with a read request every cycle that must be refused.
   task automatic run_clear();
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
   endtask

   // Asynchronous reset, asserted at a falling edge; leaves at a falling edge.
   task automatic do_reset();
      reset = 1'b0;
      bus_if.bus_req = 1'b0;
      soft_clear     = 1'b0;
      #1;
      clear_left  = DEPTH;
      init_done_m = 1'b0;
      rdata_m     = 8'h00;
      pend_q.delete();
      checkOutput("rst_rvalid", 32'(bus_if.rvalid), 32'd0);
      checkOutput("rst_rdata", 32'(bus_if.rdata), 32'd0);
      checkOutput("rst_init_done", 32'(init_done), 32'd0);
      checkOutput("rst_bus_ready", 32'(bus_if.bus_ready), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      cycle       = 0;
      bus_if.bus_req   = 1'b0;
      bus_if.bus_we    = 1'b0;
      bus_if.bus_addr  = '0;
      bus_if.bus_wdata = '0;
      soft_clear       = 1'b0;
      reset            = 1'b1;
      @(negedge clk);
      do_reset();

      // Power-up clear, then a read of $0000
      run_clear();
      applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
      idle(3);

      // Mirrors of $0123
      applyStimulus(1'b1, 1'b1, 16'h0123, 8'hA5, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0923, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h1123, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h1923, 8'h00, 1'b0);
      idle(3);

      // Out-of-window write must not land
      applyStimulus(1'b1, 1'b1, 16'h2000, 8'h5A, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0000, 8'h00, 1'b0);
      idle(3);

      // Write-then-read at the top index, then back-to-back reads
      applyStimulus(1'b1, 1'b1, 16'h07FF, 8'h3C, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h07FF, 8'h00, 1'b0);
      for (int a = 0; a < 4; a++) applyStimulus(1'b1, 1'b0, 16'(a), 8'h00, 1'b0);
      idle(3);

      // Read just before soft_clear keeps pre-clear data; soft_clear beats a read
      applyStimulus(1'b1, 1'b1, 16'h0456, 8'h77, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0456, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0123, 8'h00, 1'b1);
      run_clear();
      applyStimulus(1'b1, 1'b0, 16'h0123, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0456, 8'h00, 1'b0);
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [15:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h1FFF));
         applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), ra, 8'($urandom),
                       $urandom_range(0, 399) == 0);
      end
      idle(3);
      if (clear_left > 0) begin
         for (int i = 0; i < DEPTH && clear_left > 0; i++) idle(1);
      end

      // Reset while a read is in flight
      applyStimulus(1'b1, 1'b1, 16'h0321, 8'hC3, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0321, 8'h00, 1'b0);
      do_reset();
      run_clear();
      applyStimulus(1'b1, 1'b0, 16'h0321, 8'h00, 1'b0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
